// File: rtl/key_pkg.sv
// key_pkg: shared FSM state type and tick-period helper for key_conditioner
package key_pkg;
  typedef enum logic [2:0] {RELEASED, PRESS_DB, PRESSED, LONG_HELD, RELEASE_DB} key_state_e;
  function automatic int tick_period(input int clk_hz);
    return (clk_hz / 1000 > 1) ? clk_hz / 1000 : 1;
  endfunction
endpackage

// File: rtl/ms_tick.sv
// ms_tick: one-cycle tick every PERIOD clocks
module ms_tick #(
  parameter int PERIOD = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = $clog2(PERIOD + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == W'(PERIOD - 1);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: per-key sync, debounce, press/release/long/repeat events and sticky pending flags
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS    = 2,
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_pin,
  input  logic [NUM_KEYS-1:0] evt_clr,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [NUM_KEYS-1:0] evt_pending
);
  localparam logic [NUM_KEYS-1:0] IDLE = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW = $clog2(LONG_MS + 1);
  localparam int RW = $clog2(REPEAT_MS + 1);
  logic [NUM_KEYS-1:0] s1_q, s2_q, raw_n;
  logic tick;
  always_ff @(posedge sys_clk) {s2_q, s1_q} <= sys_rst ? {IDLE, IDLE} : {s1_q, key_pin};
  assign raw_n = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;
  ms_tick #(.PERIOD(tick_period(CLK_HZ))) u_tick (.clk(sys_clk), .rst(sys_rst), .tick(tick));
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_state_e st_q, st_d;
    logic [DW-1:0] db_q, db_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic long_q, long_d, press_q, press_d, rel_q, rel_d, lng_q, lng_d, rpt_q, rpt_d, pend_q, pend_d;
    always_comb begin
      st_d = st_q;
      db_d = db_q;
      hold_d = hold_q;
      rep_d = rep_q;
      long_d = long_q;
      press_d = 1'b0;
      rel_d = 1'b0;
      lng_d = 1'b0;
      rpt_d = 1'b0;
      pend_d = press_q | rel_q | lng_q | rpt_q | (pend_q & ~evt_clr[k]);
      // a raw-level change always wins over a tick in the same cycle
      case (st_q)
        RELEASED: if (raw_n[k]) begin
          st_d = PRESS_DB;
          db_d = '0;
        end
        PRESS_DB: if (!raw_n[k]) st_d = RELEASED;
        else if (tick) begin
          if (db_q == DW'(DEBOUNCE_MS - 1)) begin
            st_d = PRESSED;
            press_d = 1'b1;
            hold_d = '0;
            long_d = 1'b0;
          end else db_d = db_q + 1'b1;
        end
        PRESSED: if (!raw_n[k]) begin
          st_d = RELEASE_DB;
          db_d = '0;
        end else if (tick) begin
          if (hold_q == HW'(LONG_MS - 1)) begin
            st_d = LONG_HELD;
            lng_d = 1'b1;
            rep_d = '0;
            long_d = 1'b1;
          end else hold_d = hold_q + 1'b1;
        end
        LONG_HELD: if (!raw_n[k]) begin
          st_d = RELEASE_DB;
          db_d = '0;
        end else if (tick) begin
          rpt_d = rep_q == RW'(REPEAT_MS - 1);
          rep_d = rpt_d ? '0 : rep_q + 1'b1;
        end
        RELEASE_DB: if (raw_n[k]) st_d = long_q ? LONG_HELD : PRESSED;
        else if (tick) begin
          if (db_q == DW'(DEBOUNCE_MS - 1)) begin
            st_d = RELEASED;
            rel_d = 1'b1;
            long_d = 1'b0;
          end else db_d = db_q + 1'b1;
        end
        default: st_d = RELEASED;
      endcase
    end
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        st_q <= RELEASED;
        db_q <= '0;
        hold_q <= '0;
        rep_q <= '0;
        {long_q, press_q, rel_q, lng_q, rpt_q, pend_q} <= '0;
      end else begin
        st_q <= st_d;
        db_q <= db_d;
        hold_q <= hold_d;
        rep_q <= rep_d;
        {long_q, press_q, rel_q, lng_q, rpt_q, pend_q} <= {long_d, press_d, rel_d, lng_d, rpt_d, pend_d};
      end
    end
    assign key_level[k] = st_q inside {PRESSED, LONG_HELD, RELEASE_DB};
    assign key_press[k] = press_q;
    assign key_release[k] = rel_q;
    assign key_long[k] = lng_q;
    assign key_repeat[k] = rpt_q;
    assign evt_pending[k] = pend_q;
  end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter NUM_KEYS, default 2, number of independent key channels (1..8).
REQ-002 Parameter CLK_HZ, default 50000000, sys_clk frequency; one ms tick every CLK_HZ/1000 cycles.
REQ-003 Parameter DEBOUNCE_MS, default 20, consecutive stable ticks required to accept a level change.
REQ-004 Parameter LONG_MS, default 1000, held ticks after accepted press before the long-press event.
REQ-005 Parameter REPEAT_MS, default 200, auto-repeat period in ticks while long-held.
REQ-006 Parameter ACTIVE_LOW, default 1; 1 means a pin at 0 is pressed.
REQ-007 sys_clk  in  1  sole clock; all logic on its rising edge.
REQ-008 sys_rst  in  1  synchronous, active-high reset.
REQ-009 key_pin  in  NUM_KEYS  raw asynchronous key pins.
REQ-010 evt_clr  in  NUM_KEYS  write-1-to-clear for evt_pending, sampled each cycle.
REQ-011 key_level  out  NUM_KEYS  debounced pressed level (1 = pressed).
REQ-012 key_press / key_release / key_long / key_repeat  out  NUM_KEYS each  one-cycle event pulses.
REQ-013 evt_pending  out  NUM_KEYS  sticky flag, set by any event pulse, for software polling through the PIO input port.

Function
REQ-014 Each pin passes a 2-flop synchronizer, then is inverted when ACTIVE_LOW=1, giving raw_n; raw-to-FSM latency is 2 cycles.
REQ-015 Per-key FSM states: RELEASED, PRESS_DB, PRESSED, LONG_HELD, RELEASE_DB.
REQ-016 RELEASED: raw_n=1 -> PRESS_DB with db_cnt=0.
REQ-017 PRESS_DB: raw_n=0 -> RELEASED (glitch rejected, no event); on each tick db_cnt+1; when db_cnt reaches DEBOUNCE_MS -> PRESSED, key_press pulse, key_level=1, hold_cnt=0.
REQ-018 PRESSED: on tick hold_cnt+1; at LONG_MS -> LONG_HELD, key_long pulse, rep_cnt=0; raw_n=0 -> RELEASE_DB, db_cnt=0.
REQ-019 LONG_HELD: on tick rep_cnt+1; at REPEAT_MS emit key_repeat pulse and reset rep_cnt=0; raw_n=0 -> RELEASE_DB, db_cnt=0.
REQ-020 RELEASE_DB: hold_cnt/rep_cnt frozen; raw_n=1 -> return to the held state it left (PRESSED or LONG_HELD, remembered by a long flag); at db_cnt=DEBOUNCE_MS on tick -> RELEASED, key_release pulse, key_level=0.
REQ-021 Event pulses are registered, high exactly one cycle, asserted the cycle after the tick that completes the count.
REQ-022 Tick and raw-level change in the same cycle: raw-level transition takes priority, tick is not counted.
REQ-023 evt_pending[i] sets on any pulse of key i; clears on evt_clr[i]=1; simultaneous set and clear -> stays set.
REQ-024 Counters sized by clog2 of their limit + 1; no wrap-around is possible since every counter resets on reaching its limit.
REQ-025 Keys are fully independent; simultaneous events on several keys are all reported in the same cycle.

Reset
REQ-026 While sys_rst=1: all FSMs RELEASED, all counters 0, long flags 0, synchronizer flops at the released level, key_level=0, all pulses 0, evt_pending=0, tick divider 0.
REQ-027 Reset asserted mid-press discards the press with no release event; after reset a still-held key is re-debounced and produces a fresh key_press.

Structure
REQ-028 Shared package key_pkg holds the FSM state enum and the tick-period constant function.
REQ-029 Sub-module ms_tick (divider producing a one-cycle tick every CLK_HZ/1000 cycles) is instantiated once and shared by all channels; per-key FSM lives in a generate loop.

Verification (CLK_HZ=10000 -> 10 cycles/tick, DEBOUNCE_MS=4, LONG_MS=10, REPEAT_MS=3, ACTIVE_LOW=1)
REQ-030 Reset release, key_pin=all 1 for 200 cycles -> key_level=0, no pulses, evt_pending=0.
REQ-031 key_pin[0]=0 held -> key_press[0] one cycle after the 4th tick, key_level[0]=1; key_pin[1] unaffected.
REQ-032 key_pin[0] low for 25 cycles (2 ticks) then high -> no key_press, FSM back to RELEASED.
REQ-033 Hold key 0 for 200 cycles -> key_long after 10 further ticks, then key_repeat every 3 ticks; on release, key_release after 4 ticks.
REQ-034 While PRESSED, a 15-cycle release glitch -> no key_release, return to PRESSED with hold_cnt frozen; key_long delayed by the frozen ticks only.
REQ-035 Press key 0 -> evt_pending[0]=1; evt_clr[0] pulsed in the same cycle as a key_repeat -> evt_pending[0] remains 1; a later lone evt_clr -> 0; sys_rst mid-hold -> all outputs 0 next cycle.
